fifo_rd_drain: RTL

- Read-side drain engine for the team's async_fifo, living entirely in the read clock domain.
- Pops words from the FIFO via its `r_en`/`empty`/`data_out` read port, which has 1-cycle read latency.
- Re-presents the words on a valid/ready stream with packet framing (`m_last` every PKT_LEN words).
- Stops only on packet boundaries.

---
 rtl/fifo_rd_drain_pkg.sv | 17 +
 rtl/fifo_rd_skid_buf.sv | 46 ++++
 rtl/fifo_rd_drain.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_rd_drain_pkg.sv
// Shared types and constants for the fifo_rd_drain read-side drain engine.
package fifo_rd_drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } drain_state_e;

  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned BUF_DEPTH = 2;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order buffer holding {last,data} words between the FIFO read port and the stream.
module fifo_rd_skid_buf
  import fifo_rd_drain_pkg::*;
#(
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [BUF_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count < 2'(BUF_DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-domain drain engine: pops async_fifo words and re-presents them as framed packets.
// Optional statistics outputs are enabled by defining FIFO_RD_DRAIN_STATS_EN.
module fifo_rd_drain
  import fifo_rd_drain_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned PKT_LEN = 4
) (
  input  logic         rd_clk,
  input  logic         rd_rst,
  input  logic         drain_en,
  input  logic         fifo_empty,
  input  logic [W-1:0] fifo_data,
  output logic         fifo_r_en,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  output logic         m_last,
  input  logic         m_ready,
  output logic         busy
`ifdef FIFO_RD_DRAIN_STATS_EN
  ,
  output logic [15:0]  pop_count,
  output logic [15:0]  stall_count
`endif
);

  localparam int unsigned    CW   = cnt_width(PKT_LEN);
  localparam logic [CW-1:0]  LAST = CW'(PKT_LEN - 1);

  drain_state_e      state;
  logic [CW-1:0]     iss_cnt;
  logic [RD_LAT-1:0] inflight;
  logic [RD_LAT-1:0] inflight_last;
  logic [1:0]        buf_cnt;
  logic [W:0]        head;
  logic              pop;
  logic [2:0]        occ;
  logic              issue_ok;

  assign pop = m_valid && m_ready;
  assign occ = {1'b0, buf_cnt} + {2'b0, inflight[0]} - {2'b0, pop};

  always_comb begin
    issue_ok = 1'b0;
    case (state)
      RUN:     issue_ok = drain_en;
      FINISH:  issue_ok = (iss_cnt != '0);
      default: issue_ok = 1'b0;
    endcase
  end

  // RUN also gates on drain_en so a stop request never opens a new packet.
  assign fifo_r_en = issue_ok && !fifo_empty && (occ < 3'(BUF_DEPTH));

  // Framing tag is fixed at issue time; in-order delivery makes it equal out_cnt==PKT_LEN-1.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state         <= IDLE;
      iss_cnt       <= '0;
      inflight      <= '0;
      inflight_last <= '0;
    end else begin
      inflight      <= RD_LAT'(fifo_r_en);
      inflight_last <= RD_LAT'(iss_cnt == LAST);
      if (fifo_r_en) iss_cnt <= (iss_cnt == LAST) ? '0 : iss_cnt + 1'b1;
      case (state)
        IDLE: if (drain_en) state <= RUN;
        RUN: begin
          if (!drain_en) begin
            if (iss_cnt != '0) state <= FINISH;
            else if (!inflight[0] && buf_cnt == 2'd0) state <= IDLE;
          end
        end
        FINISH: begin
          if (iss_cnt == '0 && !inflight[0] && buf_cnt == 2'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_rd_skid_buf #(
    .DW (W + 1)
  ) u_buf (
    .clk       (rd_clk),
    .rst_n     (rd_rst),
    .push      (inflight[0]),
    .push_data ({inflight_last[0], fifo_data}),
    .pop       (pop),
    .head      (head),
    .count     (buf_cnt)
  );

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = head[W-1:0];
  assign m_last  = m_valid && head[W];
  assign busy    = (state != IDLE) || inflight[0] || (buf_cnt != 2'd0);

`ifdef FIFO_RD_DRAIN_STATS_EN
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      pop_count   <= '0;
      stall_count <= '0;
    end else begin
      if (fifo_r_en && pop_count != '1) pop_count <= pop_count + 16'd1;
      if (m_valid && !m_ready && stall_count != '1) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
